pc_branch_unit: RTL and testbench

- Program-counter stage directly downstream of the condition evaluator. It consumes the 1-bit taken signal, which the condition evaluator has already qualified with its Enable.
- Holds the architectural 16-bit PC and advances it sequentially. Applies conditional branches, calls and returns, using an internal return-address stack (RAS).
- Sticky fault flag on stack overflow or underflow; the fault halts PC advance until reset.
- Feeds the instruction fetch address to program memory.

---
 rtl/pc_branch_unit_pkg.sv | 15 +
 rtl/ras_stack.sv | 53 +++++
 rtl/pc_branch_unit.sv | 103 ++++++++++
 tb/tb_pc_branch_unit.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/pc_branch_unit_pkg.sv
// Shared encodings for the program-counter / branch stage.
package pc_branch_unit_pkg;

    localparam int unsigned PC_WIDTH = 16;

    localparam logic [1:0] OP_SEQ    = 2'd0;
    localparam logic [1:0] OP_BRANCH = 2'd1;
    localparam logic [1:0] OP_CALL   = 2'd2;
    localparam logic [1:0] OP_RET    = 2'd3;

    localparam logic [1:0] FLT_NONE = 2'd0;
    localparam logic [1:0] FLT_OVF  = 2'd1;
    localparam logic [1:0] FLT_UNF  = 2'd2;

endpackage

// File: rtl/ras_stack.sv
// Return-address LIFO. The caller guarantees no push when full and no pop when empty.
module ras_stack #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] top_o,
    output logic             empty_o,
    output logic             full_o
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [CW-1:0]    count_q, count_d;
    logic [AW-1:0]    wr_idx, rd_idx;

    // Low bits of count index the next free slot; the slot below it is the top.
    assign wr_idx  = count_q[AW-1:0];
    assign rd_idx  = wr_idx - AW'(1);
    assign top_o   = mem_q[rd_idx];
    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));

    always_comb begin
        count_d = count_q;
        if (push_i) begin
            count_d = count_q + CW'(1);
        end else if (pop_i) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem_q[wr_idx] <= din_i;
        end
    end

endmodule

// File: rtl/pc_branch_unit.sv
// Architectural PC with conditional branch, call/return via a RAS, and a sticky stack fault.
module pc_branch_unit
    import pc_branch_unit_pkg::*;
#(
    parameter int unsigned      WIDTH    = PC_WIDTH,
    parameter int unsigned      INC      = 1,
    parameter int unsigned      DEPTH    = 8,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             step_i,
    input  logic [1:0]       op_i,
    input  logic             taken_i,
    input  logic [WIDTH-1:0] target_i,
    output logic [WIDTH-1:0] pc_o,
    output logic [WIDTH-1:0] pc_seq_o,
    output logic             ras_empty_o,
    output logic             ras_full_o,
    output logic             fault_o,
    output logic [1:0]       fault_code_o
);

    logic [WIDTH-1:0] pc_q, pc_d;
    logic             fault_q, fault_d;
    logic [1:0]       fault_code_q, fault_code_d;
    logic             push, pop;
    logic [WIDTH-1:0] ras_top;
    logic             ras_empty, ras_full;

    assign pc_seq_o = pc_q + WIDTH'(INC);

    ras_stack #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) u_ras (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .push_i (push),
        .pop_i  (pop),
        .din_i  (pc_seq_o),
        .top_o  (ras_top),
        .empty_o(ras_empty),
        .full_o (ras_full)
    );

    always_comb begin
        pc_d         = pc_q;
        fault_d      = fault_q;
        fault_code_d = fault_code_q;
        push         = 1'b0;
        pop          = 1'b0;
        // A recorded fault freezes the PC and the stack until reset.
        if (step_i && !fault_q) begin
            unique case (op_i)
                OP_SEQ: pc_d = pc_seq_o;
                OP_BRANCH: pc_d = taken_i ? target_i : pc_seq_o;
                OP_CALL: begin
                    if (!taken_i) begin
                        pc_d = pc_seq_o;
                    end else if (ras_full) begin
                        fault_d      = 1'b1;
                        fault_code_d = FLT_OVF;
                    end else begin
                        push = 1'b1;
                        pc_d = target_i;
                    end
                end
                OP_RET: begin
                    if (!taken_i) begin
                        pc_d = pc_seq_o;
                    end else if (ras_empty) begin
                        fault_d      = 1'b1;
                        fault_code_d = FLT_UNF;
                    end else begin
                        pop  = 1'b1;
                        pc_d = ras_top;
                    end
                end
                default: pc_d = pc_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pc_q         <= RESET_PC;
            fault_q      <= 1'b0;
            fault_code_q <= FLT_NONE;
        end else begin
            pc_q         <= pc_d;
            fault_q      <= fault_d;
            fault_code_q <= fault_code_d;
        end
    end

    assign pc_o         = pc_q;
    assign ras_empty_o  = ras_empty;
    assign ras_full_o   = ras_full;
    assign fault_o      = fault_q;
    assign fault_code_o = fault_code_q;

endmodule

// File: tb/tb_pc_branch_unit.sv
// Directed table, corner-case sequences and a randomized run against a queue-based model.
module tb_pc_branch_unit;

    localparam int unsigned W = 16;
    localparam int unsigned D = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         step = 1'b0;
    logic [1:0]   op = 2'd0;
    logic         taken = 1'b0;
    logic [W-1:0] target = '0;

    logic [W-1:0] pc, pc_seq, pc2, pc_seq2;
    logic         ras_empty, ras_full, fault, ras_empty2, ras_full2, fault2;
    logic [1:0]   fault_code, fault_code2;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [W-1:0] m_pc;
    logic [W-1:0] m_stack[$];
    logic         m_fault;
    logic [1:0]   m_code;

    always #5 clk = ~clk;

    pc_branch_unit #(.WIDTH(W), .INC(1), .DEPTH(D), .RESET_PC(16'h0000)) dut (
        .clk_i(clk), .rst_i(rst), .step_i(step), .op_i(op), .taken_i(taken),
        .target_i(target), .pc_o(pc), .pc_seq_o(pc_seq), .ras_empty_o(ras_empty),
        .ras_full_o(ras_full), .fault_o(fault), .fault_code_o(fault_code)
    );

    pc_branch_unit #(.WIDTH(W), .INC(1), .DEPTH(D), .RESET_PC(16'hFFFF)) dut_wrap (
        .clk_i(clk), .rst_i(rst), .step_i(step), .op_i(op), .taken_i(taken),
        .target_i(target), .pc_o(pc2), .pc_seq_o(pc_seq2), .ras_empty_o(ras_empty2),
        .ras_full_o(ras_full2), .fault_o(fault2), .fault_code_o(fault_code2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_pc = 16'h0000;
        m_stack.delete();
        m_fault = 1'b0;
        m_code = 2'd0;
    endtask

    task automatic model_step(input logic s, input logic [1:0] o, input logic t,
                              input logic [W-1:0] tg);
        logic [W-1:0] nxt;
        nxt = W'((32'(m_pc) + 1) % 32'h10000);
        if (s && !m_fault) begin
            if (o == 2'd0 || !t) begin
                m_pc = nxt;
            end else if (o == 2'd1) begin
                m_pc = tg;
            end else if (o == 2'd2) begin
                if (m_stack.size() == D) begin
                    m_fault = 1'b1;
                    m_code = 2'd1;
                end else begin
                    m_stack.push_back(nxt);
                    m_pc = tg;
                end
            end else begin
                if (m_stack.size() == 0) begin
                    m_fault = 1'b1;
                    m_code = 2'd2;
                end else begin
                    m_pc = m_stack.pop_back();
                end
            end
        end
    endtask

    task automatic model_check(input string tag);
        chk({tag, ".pc"}, 32'(pc), 32'(m_pc));
        chk({tag, ".pc_seq"}, 32'(pc_seq), 32'(W'(32'(m_pc) + 1)));
        chk({tag, ".empty"}, 32'(ras_empty), 32'(m_stack.size() == 0));
        chk({tag, ".full"}, 32'(ras_full), 32'(m_stack.size() == D));
        chk({tag, ".fault"}, 32'(fault), 32'(m_fault));
        chk({tag, ".code"}, 32'(fault_code), 32'(m_code));
    endtask

    task automatic do_reset();
        step = 1'b0;
        rst = 1'b1;
        #2;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic drive(input logic s, input logic [1:0] o, input logic t, input logic [W-1:0] tg);
        step = s;
        op = o;
        taken = t;
        target = tg;
        tick();
        model_step(s, o, t, tg);
    endtask

    typedef struct {
        logic         s;
        logic [1:0]   o;
        logic         t;
        logic [W-1:0] tg;
        logic [W-1:0] exp_pc;
        logic         exp_empty;
    } vec_t;

    vec_t vec[13];

    initial begin
        vec[0]  = '{1'b1, 2'd0, 1'b0, 16'h0000, 16'h0001, 1'b1};
        vec[1]  = '{1'b1, 2'd0, 1'b0, 16'h0000, 16'h0002, 1'b1};
        vec[2]  = '{1'b1, 2'd0, 1'b0, 16'h0000, 16'h0003, 1'b1};
        vec[3]  = '{1'b0, 2'd0, 1'b0, 16'h0000, 16'h0003, 1'b1};
        vec[4]  = '{1'b1, 2'd1, 1'b1, 16'h0010, 16'h0010, 1'b1};
        vec[5]  = '{1'b1, 2'd1, 1'b0, 16'h0100, 16'h0011, 1'b1};
        vec[6]  = '{1'b1, 2'd1, 1'b1, 16'h0100, 16'h0100, 1'b1};
        vec[7]  = '{1'b1, 2'd1, 1'b1, 16'h0020, 16'h0020, 1'b1};
        vec[8]  = '{1'b1, 2'd2, 1'b1, 16'h0200, 16'h0200, 1'b0};
        vec[9]  = '{1'b1, 2'd3, 1'b1, 16'h0000, 16'h0021, 1'b1};
        vec[10] = '{1'b1, 2'd2, 1'b0, 16'h0300, 16'h0022, 1'b1};
        vec[11] = '{1'b1, 2'd3, 1'b0, 16'h0000, 16'h0023, 1'b1};
        vec[12] = '{1'b1, 2'd0, 1'b1, 16'h0500, 16'h0024, 1'b1};

        tick();
        do_reset();
        chk("rst.pc", 32'(pc), 32'h0);
        chk("rst.empty", 32'(ras_empty), 32'h1);
        chk("rst.full", 32'(ras_full), 32'h0);
        chk("rst.fault", 32'(fault), 32'h0);
        chk("rst.code", 32'(fault_code), 32'h0);
        chk("wrap.rst_pc", 32'(pc2), 32'hFFFF);
        chk("wrap.rst_seq", 32'(pc_seq2), 32'h0);
        chk("wrap.rst_flags", {29'd0, ras_empty2, ras_full2, fault2}, 32'h4);
        chk("wrap.rst_code", 32'(fault_code2), 32'h0);

        for (int i = 0; i < 13; i++) begin
            drive(vec[i].s, vec[i].o, vec[i].t, vec[i].tg);
            chk($sformatf("vec%0d.pc", i), 32'(pc), 32'(vec[i].exp_pc));
            chk($sformatf("vec%0d.empty", i), 32'(ras_empty), 32'(vec[i].exp_empty));
            chk($sformatf("vec%0d.fault", i), 32'(fault), 32'h0);
        end

        // Wrap: the 0xFFFF-reset instance steps to 0x0000
        do_reset();
        drive(1'b1, 2'd0, 1'b0, 16'h0000);
        chk("wrap.pc", 32'(pc2), 32'h0);
        chk("wrap.seq", 32'(pc_seq2), 32'h1);

        // Overflow
        do_reset();
        for (int i = 0; i < 8; i++) drive(1'b1, 2'd2, 1'b1, W'(16'h1000 + i));
        chk("ovf.full", 32'(ras_full), 32'h1);
        chk("ovf.pc8", 32'(pc), 32'h1007);
        drive(1'b1, 2'd2, 1'b1, 16'h2000);
        chk("ovf.pc", 32'(pc), 32'h1007);
        chk("ovf.fault", 32'(fault), 32'h1);
        chk("ovf.code", 32'(fault_code), 32'h1);
        drive(1'b1, 2'd0, 1'b0, 16'h0000);
        drive(1'b1, 2'd3, 1'b1, 16'h0000);
        chk("ovf.frozen_pc", 32'(pc), 32'h1007);
        chk("ovf.frozen_full", 32'(ras_full), 32'h1);
        chk("ovf.first_code", 32'(fault_code), 32'h1);
        do_reset();
        model_check("ovf.rst");

        // Underflow
        drive(1'b1, 2'd3, 1'b1, 16'h0000);
        chk("unf.pc", 32'(pc), 32'h0);
        chk("unf.fault", 32'(fault), 32'h1);
        chk("unf.code", 32'(fault_code), 32'h2);

        // Asynchronous reset between edges
        do_reset();
        drive(1'b1, 2'd1, 1'b1, 16'h0042);
        drive(1'b1, 2'd3, 1'b1, 16'h0000);
        chk("arst.pre_pc", 32'(pc), 32'h42);
        chk("arst.pre_fault", 32'(fault), 32'h1);
        #2;
        rst = 1'b1;
        step = 1'b1;
        op = 2'd1;
        taken = 1'b1;
        target = 16'h0777;
        #1;
        chk("arst.pc", 32'(pc), 32'h0);
        chk("arst.fault", 32'(fault), 32'h0);
        chk("arst.code", 32'(fault_code), 32'h0);
        tick();
        chk("arst.held_pc", 32'(pc), 32'h0);
        rst = 1'b0;
        model_reset();

        // Randomized run against the model
        for (int n = 0; n < 600; n++) begin
            if (m_fault && ($urandom_range(0, 3) == 0)) begin
                do_reset();
                model_check("rnd.rst");
            end
            drive($urandom_range(0, 7) != 0, 2'($urandom_range(0, 3)), 1'($urandom),
                  W'($urandom));
            model_check($sformatf("rnd%0d", n));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
